// File: rtl/traffic_tick_ctrl.sv
// Two-street traffic light FSM advanced by an external tick enable.
// Define TLC_ALLRED_EN to add an all-red clearance phase after each yellow.
module traffic_tick_ctrl #(
  parameter int unsigned YEL_TICKS     = 5,
  parameter int unsigned MIN_GRN_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [2:0] phase
);

`ifdef TLC_ALLRED_EN
  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    BG = 3'd2,
    BY = 3'd3,
    AR = 3'd4,
    BR = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    BG = 3'd2,
    BY = 3'd3
  } state_e;
`endif

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_RED = 2'b10;

  localparam logic [4:0] YEL_END = 5'(YEL_TICKS);
  localparam logic [4:0] GRN_MIN = 5'(MIN_GRN_TICKS);
  localparam logic [4:0] RED_END = 5'd2;

  state_e     state_q, state_d;
  state_e     nxt;
  logic [3:0] timer_q, timer_d;
  logic [3:0] timer_sat;
  logic [4:0] cnt;
  logic       adv;
  logic       illegal;

  // cnt is the tick count including the tick being sampled now
  always_comb begin
    cnt       = {1'b0, timer_q} + 5'd1;
    timer_sat = (timer_q == 4'hf) ? 4'hf : cnt[3:0];
    adv       = 1'b0;
    nxt       = state_q;
    illegal   = 1'b0;
    state_d   = state_q;
    timer_d   = timer_q;

    case (state_q)
      AG: begin
        adv = (cnt >= GRN_MIN) && !ta;
        nxt = AY;
      end
      AY: begin
        adv = (cnt == YEL_END);
`ifdef TLC_ALLRED_EN
        nxt = AR;
`else
        nxt = BG;
`endif
      end
      BG: begin
        adv = (cnt >= GRN_MIN) && !tb;
        nxt = BY;
      end
      BY: begin
        adv = (cnt == YEL_END);
`ifdef TLC_ALLRED_EN
        nxt = BR;
`else
        nxt = AG;
`endif
      end
`ifdef TLC_ALLRED_EN
      AR: begin
        adv = (cnt == RED_END);
        nxt = BG;
      end
      BR: begin
        adv = (cnt == RED_END);
        nxt = AG;
      end
`endif
      default: illegal = 1'b1;
    endcase

    // Corrupted state recovers without waiting for a tick
    if (illegal) begin
      state_d = AG;
      timer_d = 4'd0;
    end else if (tick) begin
      if (adv) begin
        state_d = nxt;
        timer_d = 4'd0;
      end else begin
        timer_d = timer_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= AG;
      timer_q <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    la    = L_RED;
    lb    = L_RED;
    phase = state_q;
    case (state_q)
      AG:      la = L_GRN;
      AY:      la = L_YEL;
      BG:      lb = L_GRN;
      BY:      lb = L_YEL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_tick_ctrl.sv
// Scoreboard bench for traffic_tick_ctrl (default and fast-parameter instances).
// Honours TLC_ALLRED_EN in its expected phase sequences.
module tb_traffic_tick_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic [1:0] la, lb;
  logic [2:0] phase;

  logic       rst_f = 1'b1;
  logic       tick_f = 1'b1;
  logic [1:0] la_f, lb_f;
  logic [2:0] phase_f;

  int errs = 0;
  int checks = 0;
  logic [7:0] sb_q[$];
  logic [2:0] seq[$];

  always #5 clk = ~clk;

  traffic_tick_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .ta    (ta),
    .tb    (tb),
    .la    (la),
    .lb    (lb),
    .phase (phase)
  );

  traffic_tick_ctrl #(
    .YEL_TICKS     (1),
    .MIN_GRN_TICKS (1)
  ) u_fast (
    .clk   (clk),
    .reset (rst_f),
    .tick  (tick_f),
    .ta    (ta),
    .tb    (tb),
    .la    (la_f),
    .lb    (lb_f),
    .phase (phase_f)
  );

  function automatic logic [7:0] obs(input logic [2:0] ph);
    logic [1:0] a, b;
    case (ph)
      3'd0:    begin a = 2'b00; b = 2'b10; end
      3'd1:    begin a = 2'b01; b = 2'b10; end
      3'd2:    begin a = 2'b10; b = 2'b00; end
      3'd3:    begin a = 2'b10; b = 2'b01; end
      default: begin a = 2'b10; b = 2'b10; end
    endcase
    return {1'b0, ph, a, b};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got {ph,la,lb}=%h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clk_main(input logic tk, input logic a_v,
                          input logic b_v, input logic [2:0] exp,
                          input string tag);
    @(negedge clk);
    tick = tk;
    ta   = a_v;
    tb   = b_v;
    sb_q.push_back(obs(exp));
    @(posedge clk);
    #1;
    chk(tag, {1'b0, phase, la, lb}, sb_q.pop_front());
  endtask

  task automatic period(input logic a_idle, input logic a_tk,
                        input logic b_v, input logic [2:0] cur,
                        input logic [2:0] nxt, input string tag);
    clk_main(1'b0, a_idle, b_v, cur, tag);
    clk_main(1'b0, a_idle, b_v, cur, tag);
    clk_main(1'b1, a_tk, b_v, nxt, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    ta    = 1'b0;
    tb    = 1'b0;
    #1;
    chk("reset", {1'b0, phase, la, lb}, obs(3'd0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_seg(input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) seq.push_back(ph);
  endtask

  initial begin
    logic [2:0] fast_exp[$];

    // Full cycle with default timing, tick every 3rd clk
    do_reset();
    push_seg(3'd0, 3);
    push_seg(3'd1, 5);
`ifdef TLC_ALLRED_EN
    push_seg(3'd4, 2);
`endif
    push_seg(3'd2, 3);
    push_seg(3'd3, 5);
`ifdef TLC_ALLRED_EN
    push_seg(3'd5, 2);
`endif
    push_seg(3'd0, 1);
    for (int p = 0; p < seq.size() - 1; p++)
      period(1'b0, 1'b0, 1'b0, seq[p], seq[p+1], "cycle");

    // Traffic on A holds green indefinitely
    do_reset();
    for (int p = 0; p < 20; p++)
      period(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, "ta_hold");
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, "ta_drop");

    // Sensor low only between ticks is ignored
    do_reset();
    for (int p = 0; p < 10; p++)
      period(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, "ta_gap");

    // Async reset during AY, then full minimum green again
    do_reset();
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "pre_rst");
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "pre_rst");
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, "pre_rst");
    period(1'b0, 1'b0, 1'b0, 3'd1, 3'd1, "pre_rst");
    @(negedge clk);
    chk("ay_before_rst", {1'b0, phase, la, lb}, obs(3'd1));
    reset = 1'b1;
    #1;
    chk("async_rst", {1'b0, phase, la, lb}, obs(3'd0));
    clk_main(1'b1, 1'b0, 1'b0, 3'd0, "rst_hold");
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "post_rst");
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "post_rst");
    period(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, "post_rst");

    // Tick held high, one-tick phases
    @(negedge clk);
    ta    = 1'b0;
    tb    = 1'b0;
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    chk("fast_rst", {1'b0, phase_f, la_f, lb_f}, obs(3'd0));
`ifdef TLC_ALLRED_EN
    fast_exp = '{3'd1, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd5, 3'd0, 3'd1};
`else
    fast_exp = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
`endif
    foreach (fast_exp[i]) begin
      sb_q.push_back(obs(fast_exp[i]));
      @(posedge clk);
      #1;
      chk("fast", {1'b0, phase_f, la_f, lb_f}, sb_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
